timer_capture_collector: RTL and testbench

- Sits directly downstream of the NB_INSTANCES timer array and consumes the per-instance captured buses.
- Each capture event is held per instance, then round-robin arbitration merges the events into one FIFO-buffered valid/ready stream of {instance index, captured value} records for software or a DMA readout stage.
- Events that would overwrite an undrained pending value are dropped and flagged in a sticky per-instance overflow bit.

---
 rtl/timer_capture_collector_if.sv | 30 +++
 rtl/timer_capture_collector.sv | 178 +++++++++++++++++
 tb/tb_timer_capture_collector.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_capture_collector_if.sv
// Capture-in / record-out bundle for timer_capture_collector.
// slave: the collector side; master: the timer array plus readout consumer side.
interface timer_capture_collector_if #(
  parameter int unsigned TIMER_BITWIDTH = 32,
  parameter int unsigned NB_INSTANCES   = 10,
  parameter int unsigned FIFO_DEPTH     = 16
);
  localparam int unsigned IDX_W = $clog2(NB_INSTANCES);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [NB_INSTANCES-1:0]                capture_valid;
  logic [NB_INSTANCES*TIMER_BITWIDTH-1:0] captured;
  logic                                   clear_overflow;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [IDX_W-1:0]                       out_index;
  logic [TIMER_BITWIDTH-1:0]              out_value;
  logic [LVL_W-1:0]                       fifo_level;
  logic [NB_INSTANCES-1:0]                overflow;

  modport master (
    output capture_valid, captured, clear_overflow, out_ready,
    input  out_valid, out_index, out_value, fifo_level, overflow
  );

  modport slave (
    input  capture_valid, captured, clear_overflow, out_ready,
    output out_valid, out_index, out_value, fifo_level, overflow
  );
endinterface

// File: rtl/timer_capture_collector.sv
// Collects per-instance timer capture events into a single record stream.
// Each instance holds one pending value; a round-robin arbiter moves pending
// values into a show-ahead FIFO of {index, value} records. A capture that
// arrives while its instance still holds an undrained value is dropped and
// recorded in a sticky overflow bit.
module timer_capture_collector #(
  parameter int unsigned TIMER_BITWIDTH = 32,
  parameter int unsigned NB_INSTANCES   = 10,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  timer_capture_collector_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NB_INSTANCES);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned REC_W = IDX_W + TIMER_BITWIDTH;

  // Pointer starts at the last instance so instance 0 wins first after reset.
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NB_INSTANCES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // Holding stage state
  logic [TIMER_BITWIDTH-1:0] hold_val [NB_INSTANCES];
  logic [NB_INSTANCES-1:0]   pending;
  logic [NB_INSTANCES-1:0]   overflow_q;
  logic [IDX_W-1:0]          rr_ptr;

  // FIFO state
  logic [REC_W-1:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [LVL_W-1:0]          level_q;
  logic                      out_valid_q;
  logic [IDX_W-1:0]          out_index_q;
  logic [TIMER_BITWIDTH-1:0] out_value_q;

  // Combinational helpers
  logic                      fifo_full_c;
  logic                      grant_c;
  logic [IDX_W-1:0]          grant_idx_c;
  logic [NB_INSTANCES-1:0]   grant_onehot_c;
  logic [NB_INSTANCES-1:0]   load_c;
  logic [NB_INSTANCES-1:0]   drop_c;
  logic [REC_W-1:0]          push_rec_c;
  logic                      push_c;
  logic                      pop_c;
  logic [LVL_W-1:0]          level_n;
  logic [PTR_W-1:0]          rd_ptr_n;
  logic [REC_W-1:0]          head_n;

  // Round-robin search: first pending instance after the last grant, with wrap.
  always_comb begin
    int unsigned cand;
    cand           = 0;
    grant_c        = 1'b0;
    grant_idx_c    = '0;
    grant_onehot_c = '0;
    fifo_full_c    = (level_q == LVL_FULL);
    for (int unsigned off = 1; off <= NB_INSTANCES; off++) begin
      cand = 32'(rr_ptr) + off;
      if (cand >= NB_INSTANCES) begin
        cand = cand - NB_INSTANCES;
      end
      if (!grant_c && !fifo_full_c && pending[IDX_W'(cand)]) begin
        grant_c     = 1'b1;
        grant_idx_c = IDX_W'(cand);
      end
    end
    for (int unsigned i = 0; i < NB_INSTANCES; i++) begin
      grant_onehot_c[i] = grant_c && (grant_idx_c == IDX_W'(i));
    end
  end

  // A capture loads when the slot is free or is being drained this cycle.
  always_comb begin
    load_c = '0;
    drop_c = '0;
    for (int unsigned i = 0; i < NB_INSTANCES; i++) begin
      load_c[i] = bus.capture_valid[i] && (!pending[i] || grant_onehot_c[i]);
      drop_c[i] = bus.capture_valid[i] && pending[i] && !grant_onehot_c[i];
    end
  end

  // Pending flags, sticky overflow and arbitration pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      overflow_q <= '0;
      rr_ptr     <= RR_RESET;
    end else begin
      for (int unsigned i = 0; i < NB_INSTANCES; i++) begin
        if (load_c[i]) begin
          pending[i] <= 1'b1;
        end else if (grant_onehot_c[i]) begin
          pending[i] <= 1'b0;
        end
      end
      // A fresh drop in the clearing cycle survives the clear.
      overflow_q <= (bus.clear_overflow ? '0 : overflow_q) | drop_c;
      if (grant_c) begin
        rr_ptr <= grant_idx_c;
      end
    end
  end

  // Held capture values; meaningful only while the matching pending bit is set.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB_INSTANCES; i++) begin
      if (!rst && load_c[i]) begin
        hold_val[i] <= bus.captured[i*TIMER_BITWIDTH +: TIMER_BITWIDTH];
      end
    end
  end

  assign push_c     = grant_c;
  assign pop_c      = out_valid_q && bus.out_ready;
  assign push_rec_c = {grant_idx_c, hold_val[grant_idx_c]};

  // Next level, read pointer and head record for the registered show-ahead output.
  always_comb begin
    level_n  = level_q;
    rd_ptr_n = rd_ptr;
    head_n   = '0;
    if (push_c && !pop_c) begin
      level_n = level_q + LVL_W'(1);
    end else if (!push_c && pop_c) begin
      level_n = level_q - LVL_W'(1);
    end
    if (pop_c) begin
      rd_ptr_n = rd_ptr + PTR_W'(1);
    end
    // With a push, rd == wr after the edge only when the new record is the sole entry.
    if (level_n != '0) begin
      if (push_c && (rd_ptr_n == wr_ptr)) begin
        head_n = push_rec_c;
      end else begin
        head_n = mem[rd_ptr_n];
      end
    end
  end

  // FIFO pointers, level and registered head outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_value_q <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr                     <= rd_ptr_n;
      level_q                    <= level_n;
      out_valid_q                <= (level_n != '0);
      {out_index_q, out_value_q} <= head_n;
    end
  end

  // FIFO storage; stale entries are never presented because the level gates the head.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= push_rec_c;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_index  = out_index_q;
  assign bus.out_value  = out_value_q;
  assign bus.fifo_level = level_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_timer_capture_collector.sv
// Bench for timer_capture_collector: vector table, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_timer_capture_collector;

  localparam int unsigned TW = 32;
  localparam int unsigned NI = 10;
  localparam int unsigned FD = 16;
  localparam int unsigned IW = $clog2(NI);
  localparam int unsigned LW = $clog2(FD) + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  timer_capture_collector_if #(.TIMER_BITWIDTH(TW), .NB_INSTANCES(NI), .FIFO_DEPTH(FD)) bus ();

  timer_capture_collector #(.TIMER_BITWIDTH(TW), .NB_INSTANCES(NI), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [TW-1:0] val;
  } rec_t;

  // Reference model: pending slots, record queue, last-grant index, overflow bits.
  bit            mp  [NI];
  logic [TW-1:0] mv  [NI];
  int            mrr;
  logic [NI-1:0] mov;
  rec_t          mq  [$];

  typedef struct {
    logic          r;
    logic [NI-1:0] cv;
    logic [TW-1:0] base;
    logic          rdy;
    logic          ev;
    logic [IW-1:0] eidx;
    logic [TW-1:0] evl;
    logic [LW-1:0] elvl;
    logic [NI-1:0] eov;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int            g;
    bit            pop;
    logic [NI-1:0] newov;
    rec_t          r;
    if (rst) begin
      for (int i = 0; i < NI; i++) mp[i] = 1'b0;
      mq.delete();
      mrr = NI - 1;
      mov = '0;
    end else begin
      g     = -1;
      pop   = (mq.size() != 0) && bus.out_ready;
      newov = '0;
      if (mq.size() < FD) begin
        for (int off = 1; off <= NI && g < 0; off++) begin
          if (mp[(mrr + off) % NI]) g = (mrr + off) % NI;
        end
      end
      if (pop) void'(mq.pop_front());
      if (g >= 0) begin
        r.idx = IW'(g);
        r.val = mv[g];
        mq.push_back(r);
        mp[g] = 1'b0;
        mrr   = g;
      end
      for (int i = 0; i < NI; i++) begin
        if (bus.capture_valid[i]) begin
          if (!mp[i]) begin
            mv[i] = bus.captured[i*TW +: TW];
            mp[i] = 1'b1;
          end else begin
            newov[i] = 1'b1;
          end
        end
      end
      mov = bus.clear_overflow ? newov : (mov | newov);
    end
  endtask

  task automatic model_check();
    logic          ev;
    logic [IW-1:0] ei;
    logic [TW-1:0] el;
    ev = (mq.size() != 0);
    ei = ev ? mq[0].idx : '0;
    el = ev ? mq[0].val : '0;
    check("model_out_valid", 64'(bus.out_valid), 64'(ev));
    check("model_out_index", 64'(bus.out_index), 64'(ei));
    check("model_out_value", 64'(bus.out_value), 64'(el));
    check("model_fifo_level", 64'(bus.fifo_level), 64'(mq.size()));
    check("model_overflow", 64'(bus.overflow), 64'(mov));
  endtask

  // One clock: advance the model with the applied inputs, then sample after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic set_caps(input logic [NI-1:0] cv, input logic [TW-1:0] base);
    bus.capture_valid = cv;
    for (int i = 0; i < NI; i++) bus.captured[i*TW +: TW] = base + TW'(i);
  endtask

  task automatic set_one(input int i, input logic [TW-1:0] val);
    bus.capture_valid    = '0;
    bus.capture_valid[i] = 1'b1;
    bus.captured[i*TW +: TW] = val;
  endtask

  task automatic idle();
    bus.capture_valid  = '0;
    bus.clear_overflow = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(logic r, logic [NI-1:0] cv, logic [TW-1:0] base, logic rdy,
                              logic ev, int eidx, logic [TW-1:0] evl, int elvl);
    vec_t v;
    v.r = r; v.cv = cv; v.base = base; v.rdy = rdy;
    v.ev = ev; v.eidx = IW'(eidx); v.evl = evl; v.elvl = LW'(elvl); v.eov = '0;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t got [$];
    rec_t exp [$];
    rec_t r;
    int   phase_ready;

    rst                = 1'b1;
    bus.capture_valid  = '0;
    bus.captured       = '0;
    bus.clear_overflow = 1'b0;
    bus.out_ready      = 1'b0;

    // Vector table: reset, single event on instance 3, then all-instance burst.
    tbl[0] = mk(1'b1, '0, 0, 1'b1, 1'b0, 0, 0, 0);
    tbl[1] = mk(1'b0, '0, 0, 1'b1, 1'b0, 0, 0, 0);
    tbl[2] = mk(1'b0, 10'h008, 32'h0000_1231, 1'b1, 1'b0, 0, 0, 0);
    tbl[3] = mk(1'b0, '0, 0, 1'b1, 1'b1, 3, 32'h0000_1234, 1);
    tbl[4] = mk(1'b0, '0, 0, 1'b1, 1'b0, 0, 0, 0);
    tbl[5] = mk(1'b1, '0, 0, 1'b1, 1'b0, 0, 0, 0);
    tbl[6] = mk(1'b0, '1, 100, 1'b1, 1'b0, 0, 0, 0);
    for (int k = 0; k < 10; k++) tbl[7+k] = mk(1'b0, '0, 0, 1'b1, 1'b1, k, TW'(100 + k), 1);
    tbl[17] = mk(1'b0, '0, 0, 1'b1, 1'b0, 0, 0, 0);

    for (int v = 0; v < 18; v++) begin
      rst                = tbl[v].r;
      set_caps(tbl[v].cv, tbl[v].base);
      bus.clear_overflow = 1'b0;
      bus.out_ready      = tbl[v].rdy;
      step();
      check($sformatf("vec%0d_valid", v), 64'(bus.out_valid), 64'(tbl[v].ev));
      check($sformatf("vec%0d_index", v), 64'(bus.out_index), 64'(tbl[v].eidx));
      check($sformatf("vec%0d_value", v), 64'(bus.out_value), 64'(tbl[v].evl));
      check($sformatf("vec%0d_level", v), 64'(bus.fifo_level), 64'(tbl[v].elvl));
      check($sformatf("vec%0d_overflow", v), 64'(bus.overflow), 64'(tbl[v].eov));
    end
    idle();

    // Backpressure to full, then an overflow on instance 5, then drain.
    do_reset();
    bus.out_ready = 1'b0;
    set_caps('1, 200);
    step();
    idle();
    repeat (12) step();
    check("fill1_level", 64'(bus.fifo_level), 64'd10);
    set_caps('1, 300);
    step();
    idle();
    repeat (8) step();
    check("full_level", 64'(bus.fifo_level), 64'd16);
    check("full_head_index", 64'(bus.out_index), 64'd0);
    check("full_head_value", 64'(bus.out_value), 64'd200);
    check("full_overflow", 64'(bus.overflow), 64'd0);
    set_one(5, 32'd7);
    step();
    set_one(5, 32'd9);
    step();
    idle();
    check("ovf5_set", 64'(bus.overflow), 64'h020);
    check("ovf5_level", 64'(bus.fifo_level), 64'd16);
    for (int i = 0; i < 10; i++) begin r.idx = IW'(i); r.val = TW'(200 + i); exp.push_back(r); end
    for (int i = 0; i < 10; i++) begin r.idx = IW'(i); r.val = TW'(300 + i); exp.push_back(r); end
    r.idx = IW'(5); r.val = 32'd7; exp.push_back(r);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 100 && got.size() < exp.size(); c++) begin
      if (bus.out_valid) begin
        r.idx = bus.out_index;
        r.val = bus.out_value;
        got.push_back(r);
      end
      step();
    end
    check("drain_count", 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("drain%0d_index", i), 64'(got[i].idx), 64'(exp[i].idx));
      check($sformatf("drain%0d_value", i), 64'(got[i].val), 64'(exp[i].val));
    end
    check("drain_level", 64'(bus.fifo_level), 64'd0);
    check("ovf5_sticky", 64'(bus.overflow), 64'h020);
    bus.clear_overflow = 1'b1;
    step();
    bus.clear_overflow = 1'b0;
    check("ovf_cleared", 64'(bus.overflow), 64'd0);

    // Overflow set/clear race on instance 2.
    do_reset();
    bus.out_ready = 1'b0;
    set_caps(10'h0C0, 0);
    step();
    set_one(7, 32'd77);
    step();
    idle();
    step();
    check("race_pre_ovf", 64'(bus.overflow), 64'h080);
    set_caps(10'h006, 0);
    step();
    set_one(2, 32'd22);
    bus.clear_overflow = 1'b1;
    step();
    idle();
    check("race_ovf", 64'(bus.overflow), 64'h004);

    // Reset in the middle of a stream.
    do_reset();
    bus.out_ready = 1'b0;
    set_caps('1, 500);
    step();
    set_one(9, 32'd1);
    step();
    idle();
    repeat (4) step();
    check("mid_level", 64'(bus.fifo_level), 64'd5);
    check("mid_ovf", 64'(bus.overflow), 64'h200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_level", 64'(bus.fifo_level), 64'd0);
    check("mid_rst_ovf", 64'(bus.overflow), 64'd0);
    check("mid_rst_value", 64'(bus.out_value), 64'd0);
    bus.out_ready = 1'b1;
    set_one(0, 32'h0000_0ABC);
    step();
    idle();
    check("post_rst_lat", 64'(bus.out_valid), 64'd0);
    step();
    check("post_rst_valid", 64'(bus.out_valid), 64'd1);
    check("post_rst_index", 64'(bus.out_index), 64'd0);
    check("post_rst_value", 64'(bus.out_value), 64'h0ABC);
    step();
    check("post_rst_empty", 64'(bus.fifo_level), 64'd0);

    // Randomized traffic with alternating backpressure phases.
    do_reset();
    phase_ready = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) phase_ready = (phase_ready == 0) ? 1 : 0;
      for (int i = 0; i < NI; i++) begin
        bus.capture_valid[i]     = ($urandom_range(0, 7) == 0);
        bus.captured[i*TW +: TW] = $urandom;
      end
      bus.clear_overflow = ($urandom_range(0, 30) == 0);
      bus.out_ready      = phase_ready != 0 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      rst                = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
